// File: rtl/mem_pkg.sv
// Shared types and constants for the RV32 load/store unit and its checker.
// The request struct address width is fixed here; mem_lsu's ADDR_W must match it.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    typedef struct packed {
        logic                  write;
        logic [2:0]            funct3;
        logic [LSU_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [4:0]            rd;
    } lsu_req_t;

endpackage

// File: rtl/mem_lsu_check.sv
// Combinational funct3 legality and alignment check for mem_lsu.
// MEM_LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module mem_lsu_check
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              fault_o,
    output logic [ADDR_W-1:0] addr_aligned_o
);

    logic illegal;
    logic isHalf;
    logic isWord;

    always_comb begin
        illegal = 1'b0;
        if (write_i) begin
            illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    assign isHalf = (funct3_i[1:0] == 2'b01);
    assign isWord = (funct3_i[1:0] == 2'b10);

    // Without the trap, misaligned accesses fall through to the naturally aligned slot.
    always_comb begin
        addr_aligned_o = addr_i;
        if (isHalf) begin
            addr_aligned_o[0] = 1'b0;
        end
        if (isWord) begin
            addr_aligned_o[1:0] = 2'b00;
        end
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (isHalf && addr_i[0]) || (isWord && (addr_i[1:0] != 2'b00));
    assign fault_o    = illegal || misaligned;
`else
    assign fault_o    = illegal;
`endif

endmodule

// File: rtl/mem_lsu.sv
// RV32 memory-stage load/store unit: request handshake, one-cycle data_mem access,
// held writeback response with backpressure and flush. See mem_lsu_check for MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_len,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_is_load,
    output logic              resp_fault
);

    lsu_state_t        state_q;
    lsu_req_t          req_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic [4:0]        resp_rd_q;
    logic              resp_is_load_q;
    logic              resp_fault_q;

    logic              fault;
    logic [ADDR_W-1:0] alignedAddr;
    logic              accept;
    logic              inAccess;

    mem_lsu_check #(
        .ADDR_W(ADDR_W)
    ) u_check (
        .write_i        (req_write),
        .funct3_i       (req_funct3),
        .addr_i         (req_addr),
        .fault_o        (fault),
        .addr_aligned_o (alignedAddr)
    );

    always_comb begin
        req_ready = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = resp_ready && !flush;
            default: req_ready = 1'b0;
        endcase
    end

    assign accept   = req_valid && req_ready && !flush;
    assign inAccess = (state_q == ACCESS);

    // Memory strobes exist only in ACCESS; a flush there must kill the store before the edge.
    assign mem_read  = inAccess && !req_q.write;
    assign mem_write = inAccess && req_q.write && !flush;
    assign mem_addr  = inAccess ? req_q.addr   : '0;
    assign mem_len   = inAccess ? req_q.funct3 : 3'b000;
    assign mem_wdata = inAccess ? req_q.wdata  : 32'h0;

    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_rd      = resp_rd_q;
    assign resp_is_load = resp_is_load_q;
    assign resp_fault   = resp_fault_q;

    // Later assignments in IDLE/RESP override the release path when a new request is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            req_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0;
            resp_rd_q      <= 5'd0;
            resp_is_load_q <= 1'b0;
            resp_fault_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    if (state_q == RESP && (flush || resp_ready)) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        req_q.write  <= req_write;
                        req_q.funct3 <= req_funct3;
                        req_q.addr   <= alignedAddr;
                        req_q.wdata  <= req_wdata;
                        req_q.rd     <= req_rd;
                        if (fault) begin
                            state_q        <= RESP;
                            resp_valid_q   <= 1'b1;
                            resp_fault_q   <= 1'b1;
                            resp_rdata_q   <= 32'h0;
                            resp_rd_q      <= req_rd;
                            resp_is_load_q <= !req_write;
                        end else begin
                            state_q      <= ACCESS;
                            resp_valid_q <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (flush) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end else begin
                        state_q        <= RESP;
                        resp_valid_q   <= 1'b1;
                        resp_fault_q   <= 1'b0;
                        resp_rdata_q   <= req_q.write ? 32'h0 : mem_rdata;
                        resp_rd_q      <= req_q.rd;
                        resp_is_load_q <= !req_q.write;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: hand-computed expectations checked with immediate assertions.
module tb_mem_lsu;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic [7:0]  mem_addr;
    logic [2:0]  mem_len;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_is_load;
    logic        resp_fault;

    int compared;
    int mismatched;

    mem_lsu #(
        .ADDR_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_is_load (resp_is_load),
        .resp_fault   (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [2:0] f3,
                                 input logic [7:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = v;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".req_ready"},  32'(req_ready),  32'd1);
        checkOutput({tag, ".mem_read"},   32'(mem_read),   32'd0);
        checkOutput({tag, ".mem_write"},  32'(mem_write),  32'd0);
        checkOutput({tag, ".mem_addr"},   32'(mem_addr),   32'd0);
        checkOutput({tag, ".mem_len"},    32'(mem_len),    32'd0);
        checkOutput({tag, ".mem_wdata"},  mem_wdata,       32'd0);
        checkOutput({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, ".resp_rdata"}, resp_rdata,      32'd0);
        checkOutput({tag, ".resp_rd"},    32'(resp_rd),    32'd0);
        checkOutput({tag, ".resp_load"},  32'(resp_is_load), 32'd0);
        checkOutput({tag, ".resp_fault"}, 32'(resp_fault), 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        mem_rdata  = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);

        #2;
        checkIdleOutputs("reset");
        tick;
        tick;
        rst_n = 1'b1;

        $display("[TB] LW 0x98");
        tick;
        applyStimulus(1'b1, 1'b0, F3_W, 8'h98, 32'h0, 5'd5);
        mem_rdata = 32'hDEADBEEF;
        #1;
        checkOutput("lw.idle_ready", 32'(req_ready), 32'd1);
        checkOutput("lw.idle_read",  32'(mem_read),  32'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
        checkOutput("lw.read",      32'(mem_read),   32'd1);
        checkOutput("lw.write",     32'(mem_write),  32'd0);
        checkOutput("lw.len",       32'(mem_len),    32'h2);
        checkOutput("lw.addr",      32'(mem_addr),   32'h98);
        checkOutput("lw.acc_ready", 32'(req_ready),  32'd0);
        checkOutput("lw.acc_valid", 32'(resp_valid), 32'd0);
        tick;
        #1;
        checkOutput("lw.valid",  32'(resp_valid),   32'd1);
        checkOutput("lw.rdata",  resp_rdata,        32'hDEADBEEF);
        checkOutput("lw.fault",  32'(resp_fault),   32'd0);
        checkOutput("lw.rd",     32'(resp_rd),      32'd5);
        checkOutput("lw.isload", 32'(resp_is_load), 32'd1);
        checkOutput("lw.read_off", 32'(mem_read),   32'd0);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        #1;
        checkOutput("lw.released", 32'(resp_valid), 32'd0);

        $display("[TB] SW 0x10");
        applyStimulus(1'b1, 1'b1, F3_W, 8'h10, 32'h1, 5'd6);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
        checkOutput("sw.write", 32'(mem_write), 32'd1);
        checkOutput("sw.read",  32'(mem_read),  32'd0);
        checkOutput("sw.wdata", mem_wdata,      32'h1);
        checkOutput("sw.addr",  32'(mem_addr),  32'h10);
        tick;
        #1;
        checkOutput("sw.write_off", 32'(mem_write),    32'd0);
        checkOutput("sw.valid",     32'(resp_valid),   32'd1);
        checkOutput("sw.isload",    32'(resp_is_load), 32'd0);
        checkOutput("sw.rdata",     resp_rdata,        32'h0);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;

        $display("[TB] LH 0x11");
        applyStimulus(1'b1, 1'b0, F3_H, 8'h11, 32'h0, 5'd4);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        checkOutput("lh.valid", 32'(resp_valid), 32'd1);
        checkOutput("lh.fault", 32'(resp_fault), 32'd1);
        checkOutput("lh.read",  32'(mem_read),   32'd0);
`else
        checkOutput("lh.read",  32'(mem_read),   32'd1);
        checkOutput("lh.addr",  32'(mem_addr),   32'h10);
        checkOutput("lh.len",   32'(mem_len),    32'h1);
        tick;
        #1;
        checkOutput("lh.valid", 32'(resp_valid), 32'd1);
        checkOutput("lh.fault", 32'(resp_fault), 32'd0);
`endif
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, F3_W, 8'h20, 32'h0, 5'd7);
        mem_rdata = 32'h12345678;
        tick;
        applyStimulus(1'b1, 1'b0, F3_B, 8'h21, 32'h0, 5'd9);
        #1;
        checkOutput("bp.acc_ready", 32'(req_ready), 32'd0);
        checkOutput("bp.acc_addr",  32'(mem_addr),  32'h20);
        tick;
        mem_rdata = 32'h000000AB;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp.hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("bp.hold_rdata", resp_rdata,      32'h12345678);
            checkOutput("bp.hold_rd",    32'(resp_rd),    32'd7);
            checkOutput("bp.hold_ready", 32'(req_ready),  32'd0);
            tick;
        end
        resp_ready = 1'b1;
        #1;
        checkOutput("bp.release_ready", 32'(req_ready), 32'd1);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        resp_ready = 1'b0;
        #1;
        checkOutput("bp.b2b_read",  32'(mem_read),   32'd1);
        checkOutput("bp.b2b_addr",  32'(mem_addr),   32'h21);
        checkOutput("bp.b2b_len",   32'(mem_len),    32'h0);
        checkOutput("bp.b2b_valid", 32'(resp_valid), 32'd0);
        tick;
        #1;
        checkOutput("bp.b2b_rdata", resp_rdata,    32'h000000AB);
        checkOutput("bp.b2b_rd",    32'(resp_rd),  32'd9);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;

        $display("[TB] store flushed in ACCESS");
        applyStimulus(1'b1, 1'b1, F3_W, 8'h30, 32'h55, 5'd2);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        flush = 1'b1;
        #1;
        checkOutput("fl.write", 32'(mem_write), 32'd0);
        checkOutput("fl.read",  32'(mem_read),  32'd0);
        tick;
        flush = 1'b0;
        #1;
        checkOutput("fl.valid", 32'(resp_valid), 32'd0);
        checkOutput("fl.ready", 32'(req_ready),  32'd1);
        checkOutput("fl.write_after", 32'(mem_write), 32'd0);

        $display("[TB] flush in IDLE");
        applyStimulus(1'b1, 1'b0, F3_W, 8'h40, 32'h0, 5'd1);
        flush = 1'b1;
        #1;
        checkOutput("fi.ready", 32'(req_ready), 32'd1);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        flush = 1'b0;
        #1;
        checkOutput("fi.read",  32'(mem_read),   32'd0);
        checkOutput("fi.valid", 32'(resp_valid), 32'd0);

        $display("[TB] illegal store funct3 100");
        applyStimulus(1'b1, 1'b1, 3'b100, 8'h44, 32'h77, 5'd8);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
        checkOutput("is.valid",  32'(resp_valid), 32'd1);
        checkOutput("is.fault",  32'(resp_fault), 32'd1);
        checkOutput("is.write",  32'(mem_write),  32'd0);
        checkOutput("is.rd",     32'(resp_rd),    32'd8);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;

        $display("[TB] illegal load funct3 011, then flush in RESP");
        applyStimulus(1'b1, 1'b0, 3'b011, 8'h00, 32'h0, 5'd3);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
        checkOutput("il.valid",  32'(resp_valid),   32'd1);
        checkOutput("il.fault",  32'(resp_fault),   32'd1);
        checkOutput("il.isload", 32'(resp_is_load), 32'd1);
        checkOutput("il.read",   32'(mem_read),     32'd0);
        applyStimulus(1'b1, 1'b0, F3_W, 8'h50, 32'h0, 5'd10);
        flush      = 1'b1;
        resp_ready = 1'b1;
        #1;
        checkOutput("fr.ready", 32'(req_ready), 32'd0);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        flush      = 1'b0;
        resp_ready = 1'b0;
        #1;
        checkOutput("fr.valid", 32'(resp_valid), 32'd0);
        checkOutput("fr.read",  32'(mem_read),   32'd0);

        $display("[TB] reset during ACCESS");
        applyStimulus(1'b1, 1'b0, F3_W, 8'h60, 32'h0, 5'd11);
        tick;
        applyStimulus(1'b0, 1'b0, 3'b000, 8'h00, 32'h0, 5'd0);
        #1;
        checkOutput("rs.read_before", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rs");
        tick;
        rst_n = 1'b1;
        tick;
        #1;
        checkOutput("rs.after_valid", 32'(resp_valid), 32'd0);
        checkOutput("rs.after_read",  32'(mem_read),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
